// File: rtl/dff_seq_ctrl.sv
// Serializes a latched pattern into an external DFF path, reassembles the return stream
// and flags a match. Optional DFF_SEQ_ERRCNT_EN adds an err_cnt popcount of mismatched bits.
module dff_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             q_i,
  output logic             d_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] cap_o
`ifdef DFF_SEQ_ERRCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + LAT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] cap_nxt;
  logic [CW-1:0]    cyc;
  logic [CW-1:0]    samp_idx;
  logic             sample;

  // cyc holds k during the cycle that began at edge Ek; bit k-LAT is captured at its end.
  assign samp_idx = cyc - CW'(LAT);
  assign sample   = ((state == SHIFT) || (state == DRAIN)) && (cyc >= CW'(LAT));

  always_comb begin
    cap_nxt = cap_o;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sample && (samp_idx == CW'(i))) cap_nxt[i] = q_i;
    end
  end

`ifdef DFF_SEQ_ERRCNT_EN
  localparam int EW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] diff;
  logic [EW-1:0]    ones;

  always_comb begin
    diff = cap_nxt ^ pat;
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + EW'(diff[i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat   <= '0;
      sh    <= '0;
      cap_o <= '0;
      cyc   <= '0;
      d_o   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
`ifdef DFF_SEQ_ERRCNT_EN
      err_cnt <= '0;
`endif
    end else begin
      done  <= 1'b0;
      cap_o <= cap_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            pat   <= pattern_i;
            sh    <= pattern_i;
            cap_o <= '0;
            pass  <= 1'b0;
            cyc   <= '0;
            d_o   <= pattern_i[0];
            busy  <= 1'b1;
`ifdef DFF_SEQ_ERRCNT_EN
            err_cnt <= '0;
`endif
          end
        end
        SHIFT: begin
          cyc <= cyc + 1'b1;
          sh  <= sh >> 1;
          if (cyc == CW'(WIDTH - 1)) begin
            state <= DRAIN;
            d_o   <= 1'b0;
          end else begin
            d_o <= sh[1];
          end
        end
        DRAIN: begin
          cyc <= cyc + 1'b1;
          // the final bit lands on this same edge, so judge against cap_nxt
          if (cyc == CW'(WIDTH + LAT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (cap_nxt == pat);
`ifdef DFF_SEQ_ERRCNT_EN
            err_cnt <= ones;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_seq_ctrl.sv
// Directed bench for dff_seq_ctrl: 32-bit/LAT=1 loopback instance plus an 8-bit/LAT=2 instance.
module tb_dff_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, q_i, d_o, busy, done, pass, stuck;
  logic [31:0] pattern_i, cap_o;
  logic        q_ff;

  logic        start2, q2a, q2b, d2, busy2, done2, pass2;
  logic [7:0]  pattern2, cap2;

`ifdef DFF_SEQ_ERRCNT_EN
  logic [5:0] err_cnt;
  logic [3:0] err2;
`endif

  dff_seq_ctrl #(.WIDTH(32), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_i(pattern_i), .q_i(q_i),
    .d_o(d_o), .busy(busy), .done(done), .pass(pass), .cap_o(cap_o)
`ifdef DFF_SEQ_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  dff_seq_ctrl #(.WIDTH(8), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pattern_i(pattern2), .q_i(q2b),
    .d_o(d2), .busy(busy2), .done(done2), .pass(pass2), .cap_o(cap2)
`ifdef DFF_SEQ_ERRCNT_EN
    , .err_cnt(err2)
`endif
  );

  always @(posedge clk) begin
    q_ff <= d_o;
    q2a  <= d2;
    q2b  <= q2a;
  end
  assign q_i = stuck ? 1'b0 : q_ff;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] pat, input logic [31:0] exp_cap,
                           input logic exp_pass, input int exp_err, input bit chg);
    int n;
    bit seen;
    @(negedge clk);
    pattern_i = pat;
    start     = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        check({tag, " busy after E0"}, busy, 1);
`ifdef DFF_SEQ_ERRCNT_EN
        check({tag, " err_cnt cleared"}, err_cnt, 0);
`endif
      end
      if (chg && k == 4) pattern_i = 32'hFFFF_FFFF;
      check({tag, " d_o stream"}, d_o, pat[k]);
      check({tag, " no early done"}, done, 0);
    end
    seen = 1'b0;
    n    = 31;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else check({tag, " d_o drain"}, d_o, 0);
    end
    check({tag, " done edge"}, n, 33);
    check({tag, " cap_o"}, cap_o, exp_cap);
    check({tag, " pass"}, pass, exp_pass);
`ifdef DFF_SEQ_ERRCNT_EN
    check({tag, " err_cnt"}, err_cnt, exp_err);
`else
    if (exp_err < 0) check({tag, " err_cnt arg"}, exp_err, 0);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " start in DONE ignored"}, busy, 0);
    check({tag, " done one cycle"}, done, 0);
    @(negedge clk);
    check({tag, " still idle"}, busy, 0);
    check({tag, " cap_o held"}, cap_o, exp_cap);
    check({tag, " pass held"}, pass, exp_pass);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone, nidle, first_done;
    logic [7:0] pv;
    rst_n = 1'b0; start = 1'b0; pattern_i = '0; stuck = 1'b0;
    start2 = 1'b0; pattern2 = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset d_o", d_o, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset cap_o", cap_o, 0);
    check("reset busy2", busy2, 0);

    start = 1'b1;
    pattern_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("reset overrides start busy", busy, 0);
    check("reset overrides start d_o", d_o, 0);
    start = 1'b0;
    rst_n = 1'b1;

    run_check("loopback", 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0);
    stuck = 1'b1;
    run_check("stuck0", 32'h1234_5678, 32'h0000_0000, 1'b0, 13, 1'b0);
    run_check("stuck0 zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0);
    stuck = 1'b0;
    run_check("pattern change", 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b1);

    // reset lands on E10 of a run
    @(negedge clk);
    pattern_i = 32'h1234_5678;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun reset busy", busy, 0);
    check("midrun reset d_o", d_o, 0);
    check("midrun reset done", done, 0);
    check("midrun reset cap_o", cap_o, 0);
    check("midrun reset pass", pass, 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) ndone++;
    end
    check("midrun reset no activity", ndone, 0);
    run_check("after reset", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 0, 1'b0);

    // start held high across two full runs
    @(negedge clk);
    pattern_i = 32'h1234_5678;
    start = 1'b1;
    ndone = 0;
    nidle = 0;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      if (e == 69) start = 1'b0;
      if (done) begin
        ndone++;
        check("held start done edge", e, (ndone == 1) ? 33 : 68);
      end
      if (!busy && e < 69) begin
        nidle++;
        check("held start idle edge", e, 34);
      end
    end
    check("held start run count", ndone, 2);
    check("held start idle count", nidle, 1);
    check("held start final idle", busy, 0);
    check("held start cap_o", cap_o, 32'h1234_5678);
    check("held start pass", pass, 1);

    // 8-bit, two-stage DFF loopback
    pv = 8'hA5;
    first_done = 99;
    @(negedge clk);
    pattern2 = pv;
    start2 = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (e < 8) check("lat2 d_o stream", d2, pv[e]);
      if (done2 && first_done == 99) first_done = e;
    end
    check("lat2 done edge", first_done, 10);
    check("lat2 cap_o", cap2, 8'hA5);
    check("lat2 pass", pass2, 1);
`ifdef DFF_SEQ_ERRCNT_EN
    check("lat2 err_cnt", err2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
